// File: rtl/gsram_arbiter.sv
// Round-robin arbiter sharing the single-port GSRAM between the accumulate (acc) and activation (lut) paths.
// Read-modify-write transactions are held as an atomic READ+WRITE pair.
module gsram_arbiter #(
  parameter int ROWS      = 10,
  parameter int COLS      = 10,
  parameter int ADDR_W    = 4,
  parameter int PRIO_INIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              acc_req,
  input  logic [ADDR_W-1:0] acc_row,
  input  logic [ADDR_W-1:0] acc_col,
  input  logic              acc_rmw,
  output logic              acc_gnt,
  output logic              acc_done,
  input  logic              lut_req,
  input  logic [ADDR_W-1:0] lut_row,
  input  logic [ADDR_W-1:0] lut_col,
  input  logic              lut_rmw,
  output logic              lut_gnt,
  output logic              lut_done,
  output logic [ADDR_W-1:0] GSRAM_addr_row,
  output logic [ADDR_W-1:0] GSRAM_addr_col,
  output logic              GSRAM_out,
  output logic              GSRAM_out_mux,
  output logic              GSRAM_in,
  output logic              GSRAM_in_mux,
  output logic              addr_err,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic [ADDR_W:0] ROWS_L = (ADDR_W+1)'(ROWS);
  localparam logic [ADDR_W:0] COLS_L = (ADDR_W+1)'(COLS);
  localparam logic            LAST_INIT = (PRIO_INIT == 0);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic              rmw_q, rmw_d;
  logic              bad_q, bad_d;
  logic              last_owner_q, last_owner_d;

  logic window, any_req, pick, accept;
  logic rd_cyc, wr_cyc, done;
  logic [ADDR_W-1:0] sel_row, sel_col;

  // Handshake: <x>_req is valid, <x>_gnt is a combinational ready; a transaction is
  // accepted on the rising edge where req and gnt are both high. Requests must stay
  // stable until accepted; a request dropped before its grant leaves no trace.
  always_comb begin
    window  = reset && !hold &&
              ((state_q == S_IDLE) || (state_q == S_WRITE) ||
               ((state_q == S_READ) && (!rmw_q || bad_q)));
    any_req = acc_req || lut_req;
    // pick=1 selects lut; on a tie the requester that did not win last time goes first
    pick    = (acc_req && lut_req) ? ~last_owner_q : lut_req;
    accept  = window && any_req;
    acc_gnt = accept && !pick;
    lut_gnt = accept && pick;
    sel_row = pick ? lut_row : acc_row;
    sel_col = pick ? lut_col : acc_col;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    row_d        = row_q;
    col_d        = col_q;
    rmw_d        = rmw_q;
    bad_d        = bad_q;
    last_owner_d = last_owner_q;
    if (accept) begin
      state_d      = S_READ;
      owner_d      = pick;
      row_d        = sel_row;
      col_d        = sel_col;
      rmw_d        = pick ? lut_rmw : acc_rmw;
      bad_d        = ({1'b0, sel_row} >= ROWS_L) || ({1'b0, sel_col} >= COLS_L);
      last_owner_d = pick;
    end else begin
      case (state_q)
        S_READ:  state_d = (rmw_q && !bad_q) ? S_WRITE : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      rmw_q        <= 1'b0;
      bad_q        <= 1'b0;
      last_owner_q <= LAST_INIT;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      row_q        <= row_d;
      col_q        <= col_d;
      rmw_q        <= rmw_d;
      bad_q        <= bad_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Out-of-range reads keep the GSRAM fully quiet and only flag addr_err.
  always_comb begin
    rd_cyc         = (state_q == S_READ) && !bad_q;
    wr_cyc         = (state_q == S_WRITE);
    done           = (rd_cyc && !rmw_q) || wr_cyc;
    GSRAM_addr_row = (rd_cyc || wr_cyc) ? row_q : '0;
    GSRAM_addr_col = (rd_cyc || wr_cyc) ? col_q : '0;
    GSRAM_out      = rd_cyc;
    GSRAM_out_mux  = rd_cyc && owner_q;
    GSRAM_in       = wr_cyc;
    GSRAM_in_mux   = wr_cyc && owner_q;
    acc_done       = done && !owner_q;
    lut_done       = done && owner_q;
    addr_err       = (state_q == S_READ) && bad_q;
    dbg_state      = state_q;
  end

endmodule
